// File: rtl/clear_line_compact.sv
// Removes full rows from a ROWS x COLS board held in external memory, shifting the
// remaining rows down cell by cell and zero-filling the vacated rows at the top.
module clear_line_compact #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 3,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [0:ROWS-1]   line_full,
  output logic [ROW_W-1:0]  pos_i,
  output logic [COL_W-1:0]  pos_j,
  output logic              read,
  output logic              write,
  output logic [CELL_W-1:0] write_data,
  input  logic [CELL_W-1:0] rd_data,
  output logic              busy,
  output logic              clear_line_done,
  output logic [ROW_W:0]    lines_cleared
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_COPY_RD,
    S_COPY_WR,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t            r_state, w_next;
  logic [0:ROWS-1]   r_mask;
  logic [ROW_W-1:0]  r_src, r_dst;
  logic [COL_W-1:0]  r_j;
  logic [ROW_W:0]    r_lc;

  logic w_hit, w_src_top, w_dst_top, w_last_col, w_skip;

  assign w_hit      = r_mask[r_src];
  assign w_src_top  = (r_src == '0);
  assign w_dst_top  = (r_dst == '0);
  assign w_last_col = (r_j == LAST_COL);
  // src==dst means no full row seen yet below, so this row is already in place
  assign w_skip     = w_hit || (r_src == r_dst);

  always_comb begin
    w_next          = r_state;
    pos_i           = '0;
    pos_j           = '0;
    read            = 1'b0;
    write           = 1'b0;
    write_data      = '0;
    busy            = (r_state != S_IDLE);
    clear_line_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = (line_full != '0) ? S_SCAN : S_DONE;
      end
      S_SCAN: begin
        if (!w_skip)        w_next = S_COPY_RD;
        else if (w_src_top) w_next = (w_hit || r_lc != '0) ? S_FILL : S_DONE;
      end
      S_COPY_RD: begin
        read   = 1'b1;
        pos_i  = r_src;
        pos_j  = r_j;
        w_next = S_COPY_WR;
      end
      S_COPY_WR: begin
        write      = 1'b1;
        pos_i      = r_dst;
        pos_j      = r_j;
        write_data = rd_data;
        if (!w_last_col)    w_next = S_COPY_RD;
        else if (w_src_top) w_next = S_FILL;
        else                w_next = S_SCAN;
      end
      S_FILL: begin
        write = 1'b1;
        pos_i = r_dst;
        pos_j = r_j;
        if (w_last_col && w_dst_top) w_next = S_DONE;
      end
      S_DONE: begin
        clear_line_done = 1'b1;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_j     <= '0;
      r_lc    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_lc <= '0;
            if (line_full != '0) begin
              r_mask <= line_full;
              r_src  <= LAST_ROW;
              r_dst  <= LAST_ROW;
            end
          end
        end
        S_SCAN: begin
          r_j <= '0;
          if (w_hit) begin
            r_lc <= r_lc + 1'b1;
            if (!w_src_top) r_src <= r_src - 1'b1;
          end else if (r_src == r_dst && !w_src_top) begin
            r_src <= r_src - 1'b1;
            r_dst <= r_dst - 1'b1;
          end
        end
        S_COPY_WR: begin
          if (w_last_col) begin
            r_j   <= '0;
            r_dst <= r_dst - 1'b1;
            if (!w_src_top) r_src <= r_src - 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_FILL: begin
          if (w_last_col) begin
            r_j <= '0;
            if (!w_dst_top) r_dst <= r_dst - 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lines_cleared = r_lc;

endmodule

// File: tb/tb_clear_line_compact.sv
// Bench for clear_line_compact: board memory model, queue-based scoreboard fed by a
// row-compaction reference model, and a forked monitor checking each completion.
module tb_clear_line_compact;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int CELL_W = 3;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int RW     = COLS * CELL_W;
  localparam int IW     = ROWS * RW;

  typedef logic [IW-1:0]   img_t;
  typedef logic [RW-1:0]   row_t;
  typedef logic [0:ROWS-1] mask_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  mask_t             line_full = '0;
  logic [ROW_W-1:0]  pos_i;
  logic [COL_W-1:0]  pos_j;
  logic              read, write;
  logic [CELL_W-1:0] write_data;
  logic [CELL_W-1:0] rd_data = '0;
  logic              busy, clear_line_done;
  logic [ROW_W:0]    lines_cleared;

  img_t mem;
  img_t pl_img = '0;
  logic pl_go = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  int   exp_lc[$];
  int   exp_cyc[$];
  int   exp_rd[$];
  int   exp_wr[$];
  img_t exp_img[$];

  clear_line_compact #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .ROW_W(ROW_W), .COL_W(COL_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .line_full(line_full),
    .pos_i(pos_i), .pos_j(pos_j), .read(read), .write(write),
    .write_data(write_data), .rd_data(rd_data), .busy(busy),
    .clear_line_done(clear_line_done), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_go) mem <= pl_img;
    else begin
      if (read)  rd_data <= mem[(int'(pos_i) * COLS + int'(pos_j)) * CELL_W +: CELL_W];
      if (write) mem[(int'(pos_i) * COLS + int'(pos_j)) * CELL_W +: CELL_W] <= write_data;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic row_t get_row(input img_t img, input int r);
    return img[r*RW +: RW];
  endfunction

  function automatic img_t mod7_img();
    img_t x;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        x[(r*COLS + c)*CELL_W +: CELL_W] = CELL_W'(r % 7);
    return x;
  endfunction

  function automatic img_t rand_img();
    img_t x;
    for (int i = 0; i < ROWS*COLS; i++)
      x[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic monitor();
    int bc = 0, nr = 0, nw = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bc = 0; nr = 0; nw = 0;
      end else begin
        check("rd_wr_exclusive", int'(read && write), 0);
        if (read)  nr++;
        if (write) nw++;
        if (busy && !clear_line_done) bc++;
        if (clear_line_done) begin
          if (exp_lc.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got a completion pulse, expected none");
          end else begin
            int bad;
            int first;
            img_t e;
            bad = 0; first = 0;
            e = exp_img.pop_front();
            check("lines_cleared", int'(lines_cleared), exp_lc.pop_front());
            check("busy_cycles",   bc, exp_cyc.pop_front());
            check("read_strobes",  nr, exp_rd.pop_front());
            check("write_strobes", nw, exp_wr.pop_front());
            for (int r = ROWS-1; r >= 0; r--)
              if (get_row(mem, r) !== get_row(e, r)) begin
                bad++; first = r;
              end
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL board: %0d rows differ, row %0d got %h expected %h",
                       bad, first, get_row(mem, first), get_row(e, first));
            end
          end
          bc = 0; nr = 0; nw = 0;
          done_cnt++;
        end
      end
    end
  endtask

  task automatic preload(input img_t img);
    @(negedge clk);
    pl_img = img;
    pl_go  = 1'b1;
    @(negedge clk);
    pl_go  = 1'b0;
  endtask

  task automatic start(input mask_t m, input bit repulse);
    @(negedge clk);
    enable = 1'b1;
    line_full = m;
    @(negedge clk);
    enable = 1'b0;
    line_full = mask_t'($urandom);
    if (repulse) begin
      repeat (3) @(negedge clk);
      enable = 1'b1;
      line_full = mask_t'($urandom);
      repeat (4) @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev, input string nm);
    int k = 0;
    while (done_cnt == prev && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check({"done_within_bound_", nm}, int'(done_cnt != prev), 1);
  endtask

  // Reference: survivors keep their order and sink to the bottom; zeros above.
  task automatic run_op(input img_t img, input mask_t m, input bit repulse, input string nm);
    row_t q[$];
    img_t e;
    int lc = 0, moved = 0, prev;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (m[r]) lc++;
      else begin
        q.push_back(get_row(img, r));
        if (lc > 0) moved++;
      end
    end
    e = '0;
    for (int r = ROWS-1; r >= 0; r--)
      if (q.size() > 0) e[r*RW +: RW] = q.pop_front();
    preload(img);
    exp_lc.push_back(lc);
    exp_cyc.push_back((m == '0) ? 0 : ROWS + 2*COLS*moved + COLS*lc);
    exp_rd.push_back(COLS * moved);
    exp_wr.push_back(COLS * (moved + lc));
    exp_img.push_back(e);
    prev = done_cnt;
    start(m, repulse);
    wait_done(prev, nm);
  endtask

  task automatic outputs_zero(input string pfx);
    check({pfx, "_pos_i"},      int'(pos_i), 0);
    check({pfx, "_pos_j"},      int'(pos_j), 0);
    check({pfx, "_read"},       int'(read), 0);
    check({pfx, "_write"},      int'(write), 0);
    check({pfx, "_write_data"}, int'(write_data), 0);
    check({pfx, "_busy"},       int'(busy), 0);
    check({pfx, "_done"},       int'(clear_line_done), 0);
    check({pfx, "_lines"},      int'(lines_cleared), 0);
  endtask

  initial begin
    mask_t m;
    int k, n;
    fork
      monitor();
    join_none

    #12;
    outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    run_op(rand_img(), '0, 1'b0, "empty");
    run_op(mod7_img(), mask_t'(20'd1), 1'b0, "bottom");
    m = '0; m[5] = 1'b1; m[19] = 1'b1;
    run_op(mod7_img(), m, 1'b0, "rows5_19");
    m = '0; m[0] = 1'b1;
    run_op(mod7_img(), m, 1'b0, "top_only");
    run_op(rand_img(), '1, 1'b1, "all_full");
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < ROWS; r++) m[r] = ($urandom_range(0, 3) == 0);
      run_op(rand_img(), m, 1'b0, "random");
    end

    preload(mod7_img());
    start(mask_t'(20'd1), 1'b0);
    k = 0;
    while (!write && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_copy_wr", int'(write), 1);
    reset = 1'b0;
    #1;
    outputs_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (read || write || busy) n++;
    end
    check("post_abort_activity", n, 0);

    for (int r = 0; r < ROWS; r++) m[r] = ($urandom_range(0, 2) == 0);
    m[ROWS-1] = 1'b1;
    run_op(rand_img(), m, 1'b0, "recovery");

    check("pending_expectations", exp_lc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
